// File: rtl/iccm_arb_pkg.sv
// ============================================================================
//  Module      : iccm_arb_pkg
//  Description : Shared types for the ICCM port arbiter (mode, grant, beat).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iccm_arb_pkg;

  // Word-address width carried by a programming beat; the arbiter's AW must match.
  localparam int ICCM_AW = 14;

  typedef enum logic [1:0] {
    ARB_RUN   = 2'd0,
    ARB_PROG  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_WRITE = 2'd2
  } grant_e;

  typedef struct packed {
    logic [ICCM_AW-1:0] addr;
    logic [31:0]        wdata;
  } prog_beat_t;

endpackage

`default_nettype wire

// File: rtl/iccm_prog_fifo.sv
// ============================================================================
//  Module      : iccm_prog_fifo
//  Description : Synchronous FIFO of programming beats; wrap-bit pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iccm_prog_fifo
  import iccm_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  prog_beat_t data_i,
  output logic       full_o,
  output logic       empty_o,
  output prog_beat_t head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_q, wr_d;
  logic [PW:0] rd_q, rd_d;
  logic        push_ok;
  logic        pop_ok;
  prog_beat_t  buf_q [DEPTH];

  // Full/empty come straight from the pointer registers, so ready never
  // depends on a same-cycle pop.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head_o  = buf_q[rd_q[PW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) buf_q[wr_q[PW-1:0]] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/iccm_port_arbiter.sv
// ============================================================================
//  Module      : iccm_port_arbiter
//  Description : Shares the single-port ICCM between programming writes and
//                instruction fetch. Optional write checksum: ICCM_PROG_CSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iccm_port_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int AW         = ICCM_AW,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          prog_mode_i,
  input  logic          prog_valid_i,
  output logic          prog_ready_o,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [31:0]   prog_wdata_i,
  input  logic          fetch_req_i,
  output logic          fetch_gnt_o,
  input  logic [AW-1:0] fetch_addr_i,
  output logic          fetch_rvalid_o,
  output logic [31:0]   fetch_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          prog_done_o,
  output logic [31:0]   prog_csum_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  grant_e        grant;
  logic [SW-1:0] starve_q, starve_d;
  logic          rvalid_q;
  logic          starved;
  logic          fifo_full, fifo_empty;
  prog_beat_t    fifo_in, fifo_head;

  assign fifo_in = '{addr: prog_addr_i, wdata: prog_wdata_i};

  iccm_prog_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (prog_valid_i),
    .pop_i   (grant == GNT_WRITE),
    .data_i  (fifo_in),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign starved = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    grant       = GNT_NONE;
    prog_done_o = 1'b0;
    starve_d    = starve_q;
    case (state_q)
      ARB_RUN: begin
        // Entering PROG suppresses any access this cycle.
        if (prog_mode_i)                                 state_d = ARB_PROG;
        else if (fetch_req_i && !fifo_full && !starved)  grant   = GNT_FETCH;
        else if (!fifo_empty)                            grant   = GNT_WRITE;
      end
      ARB_PROG: begin
        if (!prog_mode_i) state_d = ARB_DRAIN;
        if (!fifo_empty)  grant   = GNT_WRITE;
      end
      ARB_DRAIN: begin
        if (prog_mode_i) begin
          state_d = ARB_PROG;
        end else if (fifo_empty) begin
          state_d     = ARB_RUN;
          prog_done_o = 1'b1;
        end
        if (!fifo_empty) grant = GNT_WRITE;
      end
      default: state_d = ARB_RUN;
    endcase
    if (grant == GNT_WRITE)                      starve_d = '0;
    else if (grant == GNT_FETCH && !fifo_empty)  starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_RUN;
      starve_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= (grant == GNT_FETCH);
    end
  end

  assign prog_ready_o   = !fifo_full;
  assign fetch_gnt_o    = (grant == GNT_FETCH);
  assign fetch_rvalid_o = rvalid_q;
  assign fetch_rdata_o  = mem_rdata_i;
  assign mem_req_o      = (grant != GNT_NONE);
  assign mem_we_o       = (grant == GNT_WRITE);
  assign mem_addr_o     = (grant == GNT_WRITE) ? fifo_head.addr :
                          (grant == GNT_FETCH) ? fetch_addr_i   : '0;
  assign mem_wdata_o    = (grant == GNT_WRITE) ? fifo_head.wdata : '0;

`ifdef ICCM_PROG_CSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == ARB_RUN && state_d == ARB_PROG) csum_d = '0;
    else if (grant == GNT_WRITE)                   csum_d = csum_q + fifo_head.wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) csum_q <= '0;
    else         csum_q <= csum_d;
  end

  assign prog_csum_o = csum_q;
`else
  assign prog_csum_o = '0;
`endif

endmodule

`default_nettype wire
